// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and time limits for the multi-slot alarm controller
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam logic [6:0] SEC_MAX  = 7'd59;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] HOUR_MAX = 7'd23;

  typedef struct packed {
    logic [6:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
  } hms_t;

  // True when the hh:mm:ss triple is a legal time of day.
  function automatic logic time_valid(input hms_t t);
    return (t.sec <= SEC_MAX) && (t.min <= MIN_MAX) && (t.hour <= HOUR_MAX);
  endfunction

endpackage

// File: rtl/multi_alarm_ctrl_if.sv
// rtl/multi_alarm_ctrl_if.sv - slot write port from the key/UART setting path
interface multi_alarm_ctrl_if #(
  parameter int IDX_W = 2
);
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [6:0]       wr_sec;
  logic [6:0]       wr_min;
  logic [6:0]       wr_hour;
  logic             wr_arm;
  logic             wr_err;

  modport master (
    output wr_en, wr_idx, wr_sec, wr_min, wr_hour, wr_arm,
    input  wr_err
  );

  modport slave (
    input  wr_en, wr_idx, wr_sec, wr_min, wr_hour, wr_arm,
    output wr_err
  );
endinterface

// File: rtl/alarm_slot.sv
// rtl/alarm_slot.sv - one alarm slot: stored time, arm flag, write decode and comparator
module alarm_slot
  import alarm_pkg::*;
#(
  parameter int IDX_W = 2,
  parameter int SLOT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_ok,
  input  logic [IDX_W-1:0] wr_idx,
  input  hms_t             wr_time,
  input  logic             wr_arm,
  input  hms_t             cur_time,
  input  logic             sec_tick,
  output logic             armed,
  output logic             match
);

  hms_t stored;
  logic sel;

  assign sel = wr_ok && (wr_idx == IDX_W'(SLOT));

  // Stored time and arm flag; updated only by a validated write addressed to this slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      stored <= '0;
      armed  <= 1'b0;
    end else if (sel) begin
      stored <= wr_time;
      armed  <= wr_arm;
    end
  end

  // Compare uses the registered values, so a same-cycle write does not affect this tick.
  assign match = sec_tick && armed && (stored == cur_time);

endmodule

// File: rtl/multi_alarm_ctrl.sv
// rtl/multi_alarm_ctrl.sv - N-slot alarm controller top; snooze built only with ALARM_SNOOZE_EN
module multi_alarm_ctrl #(
  parameter int N_ALARMS    = 4,
  parameter int IDX_W       = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sec_tick,
  input  logic [6:0]          cur_sec,
  input  logic [6:0]          cur_min,
  input  logic [6:0]          cur_hour,
  multi_alarm_ctrl_if.slave   wr_bus,
  input  logic                stop,
  input  logic                snooze,
  output logic                music_out,
  output logic [IDX_W-1:0]    ring_idx,
  output logic                snoozing,
  output logic [N_ALARMS-1:0] armed,
  output logic [N_ALARMS-1:0] pending
);
  import alarm_pkg::*;

  localparam int RC_W = $clog2(RING_SECS + 1);
  localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_SECS - 1);

  state_t               state, state_next;
  hms_t                 cur_time, wr_time;
  logic                 wr_ok, grant, disarm_hit, snz_ok, snz_done;
  logic [N_ALARMS-1:0]  match_vec, clr;
  logic [IDX_W-1:0]     sel_idx;
  logic [RC_W-1:0]      ring_cnt;

  assign cur_time = {cur_hour, cur_min, cur_sec};
  assign wr_time  = {wr_bus.wr_hour, wr_bus.wr_min, wr_bus.wr_sec};
  assign wr_ok    = wr_bus.wr_en && (int'(wr_bus.wr_idx) < N_ALARMS) && time_valid(wr_time);

  for (genvar g = 0; g < N_ALARMS; g++) begin : g_slot
    alarm_slot #(.IDX_W(IDX_W), .SLOT(g)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .wr_ok    (wr_ok),
      .wr_idx   (wr_bus.wr_idx),
      .wr_time  (wr_time),
      .wr_arm   (wr_bus.wr_arm),
      .cur_time (cur_time),
      .sec_tick (sec_tick),
      .armed    (armed[g]),
      .match    (match_vec[g])
    );
  end

  // Rejected writes report one cycle later.
  always_ff @(posedge clk) begin
    if (reset) wr_bus.wr_err <= 1'b0;
    else       wr_bus.wr_err <= wr_bus.wr_en && !wr_ok;
  end

  // Lowest-index pending slot wins.
  always_comb begin
    sel_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = IDX_W'(i);
    end
  end

  assign grant      = (state == IDLE) && (|pending);
  assign disarm_hit = wr_ok && !wr_bus.wr_arm && (wr_bus.wr_idx == ring_idx) && (state != IDLE);

  // Pending bits to drop: the slot being granted, or the ringing slot being disarmed.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      if (grant && (sel_idx == IDX_W'(i)))     clr[i] = 1'b1;
      if (disarm_hit && (ring_idx == IDX_W'(i))) clr[i] = 1'b1;
    end
  end

  // Matches accumulate without counting; clears win over a same-cycle re-match.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending | match_vec) & ~clr;
  end

`ifdef ALARM_SNOOZE_EN
  localparam int SC_W = $clog2(SNOOZE_SECS + 1);
  localparam int SU_W = $clog2(MAX_SNOOZE + 1);
  localparam logic [SC_W-1:0] SNZ_LAST = SC_W'(SNOOZE_SECS - 1);

  logic [SC_W-1:0] snz_cnt;
  logic [SU_W-1:0] snz_used;

  assign snz_ok   = snooze && (snz_used < SU_W'(MAX_SNOOZE));
  assign snz_done = sec_tick && (snz_cnt == SNZ_LAST);

  // Snooze interval counter runs only while snoozing and saturates at its last value.
  always_ff @(posedge clk) begin
    if (reset || state != SNOOZE)                snz_cnt <= '0;
    else if (sec_tick && snz_cnt != SNZ_LAST)    snz_cnt <= snz_cnt + SC_W'(1);
  end

  // Snoozes used in the current ring event; reset whenever the controller is idle.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE)                          snz_used <= '0;
    else if (state == RING && state_next == SNOOZE)      snz_used <= snz_used + SU_W'(1);
  end
`else
  logic unused_snz;
  assign unused_snz = snooze ^ (SNOOZE_SECS > 0) ^ (MAX_SNOOZE > 0);
  assign snz_ok     = 1'b0;
  assign snz_done   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: stop > disarm of the ringing slot > snooze > timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (|pending) state_next = RING;
      RING: begin
        if (stop || disarm_hit)                         state_next = IDLE;
        else if (snz_ok)                                state_next = SNOOZE;
        else if (sec_tick && ring_cnt == RING_LAST)     state_next = IDLE;
      end
      SNOOZE: begin
        if (stop || disarm_hit) state_next = IDLE;
        else if (snz_done)      state_next = RING;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    music_out = (state == RING);
`ifdef ALARM_SNOOZE_EN
    snoozing  = (state == SNOOZE);
`else
    snoozing  = 1'b0;
`endif
  end

  // Ring duration counter; zero outside RING so each (re)entry starts fresh.
  always_ff @(posedge clk) begin
    if (reset || state != RING)                  ring_cnt <= '0;
    else if (sec_tick && ring_cnt != RING_LAST)  ring_cnt <= ring_cnt + RC_W'(1);
  end

  // Ringing slot is latched at grant and held through snooze.
  always_ff @(posedge clk) begin
    if (reset)      ring_idx <= '0;
    else if (grant) ring_idx <= sel_idx;
  end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// tb/tb_multi_alarm_ctrl.sv - directed table-driven bench for multi_alarm_ctrl
module tb_multi_alarm_ctrl;

  logic       clk = 1'b0;
  logic       reset, sec_tick, stop, snooze;
  logic [6:0] cur_sec, cur_min, cur_hour;
  logic       music_out, snoozing;
  logic [1:0] ring_idx;
  logic [3:0] armed, pending;

  int n_checks = 0;
  int n_errors = 0;

  multi_alarm_ctrl_if #(.IDX_W(2)) bus ();

  multi_alarm_ctrl #(
    .N_ALARMS(4), .IDX_W(2), .RING_SECS(3), .SNOOZE_SECS(2), .MAX_SNOOZE(3)
  ) dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour),
    .wr_bus(bus), .stop(stop), .snooze(snooze),
    .music_out(music_out), .ring_idx(ring_idx), .snoozing(snoozing),
    .armed(armed), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] idx;
    logic [6:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
    logic       arm;
    logic       exp_err;
    logic [3:0] exp_armed;
  } wr_vec_t;

  wr_vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [6:0] h, input logic [6:0] m, input logic [6:0] s);
    cur_hour = h; cur_min = m; cur_sec = s;
  endtask

  task automatic pulse_tick();
    sec_tick = 1'b1; step(); sec_tick = 1'b0;
  endtask

  task automatic write(input logic [1:0] idx, input logic [6:0] h, input logic [6:0] m,
                       input logic [6:0] s, input logic arm);
    bus.wr_en = 1'b1; bus.wr_idx = idx; bus.wr_hour = h; bus.wr_min = m; bus.wr_sec = s;
    bus.wr_arm = arm;
    step();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'd1, 7'd7,  7'd0,  7'd0,  1'b1, 1'b0, 4'b0010};
    vecs[1] = '{2'd0, 7'd8,  7'd0,  7'd60, 1'b1, 1'b1, 4'b0010};
    vecs[2] = '{2'd2, 7'd8,  7'd60, 7'd0,  1'b1, 1'b1, 4'b0010};
    vecs[3] = '{2'd1, 7'd24, 7'd0,  7'd0,  1'b0, 1'b1, 4'b0010};
    vecs[4] = '{2'd3, 7'd23, 7'd59, 7'd59, 1'b1, 1'b0, 4'b1010};
    vecs[5] = '{2'd3, 7'd0,  7'd0,  7'd0,  1'b0, 1'b0, 4'b0010};
    vecs[6] = '{2'd0, 7'd8,  7'd0,  7'd0,  1'b1, 1'b0, 4'b0011};
    vecs[7] = '{2'd2, 7'd8,  7'd0,  7'd0,  1'b1, 1'b0, 4'b0111};

    reset = 1'b1; sec_tick = 1'b0; stop = 1'b0; snooze = 1'b0;
    set_time(7'd0, 7'd0, 7'd1);
    bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_hour = '0; bus.wr_min = '0; bus.wr_sec = '0;
    bus.wr_arm = 1'b0;
    step(); step();
    reset = 1'b0;

    check("rst_music",    32'(music_out),  32'd0);
    check("rst_ring_idx", 32'(ring_idx),   32'd0);
    check("rst_snoozing", 32'(snoozing),   32'd0);
    check("rst_armed",    32'(armed),      32'd0);
    check("rst_pending",  32'(pending),    32'd0);
    check("rst_wr_err",   32'(bus.wr_err), 32'd0);

    for (int i = 0; i < 8; i++) begin
      write(vecs[i].idx, vecs[i].hour, vecs[i].min, vecs[i].sec, vecs[i].arm);
      check($sformatf("vec%0d_wr_err", i), 32'(bus.wr_err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_armed", i),  32'(armed),      32'(vecs[i].exp_armed));
      check($sformatf("vec%0d_music", i),  32'(music_out),  32'd0);
    end
    step();
    check("wr_err_one_cycle", 32'(bus.wr_err), 32'd0);

    // Slot 1 at 07:00:00 rings; the rejected hour=24 write left it intact.
    set_time(7'd7, 7'd0, 7'd0);
    pulse_tick();
    set_time(7'd7, 7'd0, 7'd1);
    check("a_pending", 32'(pending),   32'b0010);
    check("a_music0",  32'(music_out), 32'd0);
    step();
    check("a_music1",  32'(music_out), 32'd1);
    check("a_idx",     32'(ring_idx),  32'd1);
    check("a_pend_clr", 32'(pending),  32'd0);
    step(); step();
    check("a_no_tick_hold", 32'(music_out), 32'd1);
    pulse_tick();
    check("a_tick1", 32'(music_out), 32'd1);
    pulse_tick();
    check("a_tick2", 32'(music_out), 32'd1);
    pulse_tick();
    check("a_timeout", 32'(music_out), 32'd0);
    check("a_armed_kept", 32'(armed[1]), 32'd1);

    // Slots 0 and 2 match together: 0 first, stop, then 2.
    set_time(7'd8, 7'd0, 7'd0);
    pulse_tick();
    set_time(7'd8, 7'd0, 7'd1);
    check("b_pending", 32'(pending), 32'b0101);
    step();
    check("b_idx0",    32'(ring_idx),  32'd0);
    check("b_music0",  32'(music_out), 32'd1);
    check("b_pend",    32'(pending),   32'b0100);
    stop = 1'b1; step(); stop = 1'b0;
    check("b_stopped", 32'(music_out), 32'd0);
    step();
    check("b_idx2",    32'(ring_idx),  32'd2);
    check("b_music2",  32'(music_out), 32'd1);
    check("b_pend0",   32'(pending),   32'd0);

    // Disarm the ringing slot.
    write(2'd2, 7'd8, 7'd0, 7'd0, 1'b0);
    check("c_music",  32'(music_out), 32'd0);
    check("c_armed",  32'(armed),     32'b0011);
    check("c_wr_err", 32'(bus.wr_err), 32'd0);

    // Ring slot 1 again for the snooze tests.
    set_time(7'd7, 7'd0, 7'd0);
    pulse_tick();
    set_time(7'd7, 7'd0, 7'd1);
    step();
    check("d_music", 32'(music_out), 32'd1);
    check("d_idx",   32'(ring_idx),  32'd1);
`ifdef ALARM_SNOOZE_EN
    for (int k = 1; k <= 3; k++) begin
      snooze = 1'b1; step(); snooze = 1'b0;
      check($sformatf("d_snz%0d_snoozing", k), 32'(snoozing),  32'd1);
      check($sformatf("d_snz%0d_music", k),    32'(music_out), 32'd0);
      check($sformatf("d_snz%0d_idx", k),      32'(ring_idx),  32'd1);
      pulse_tick();
      check($sformatf("d_snz%0d_tick1", k),    32'(snoozing),  32'd1);
      pulse_tick();
      check($sformatf("d_snz%0d_back", k),     32'(music_out), 32'd1);
      check($sformatf("d_snz%0d_idx2", k),     32'(ring_idx),  32'd1);
    end
    snooze = 1'b1; step(); snooze = 1'b0;
    check("d_snz4_ignored_music", 32'(music_out), 32'd1);
    check("d_snz4_ignored_snz",   32'(snoozing),  32'd0);
`else
    snooze = 1'b1; step(); snooze = 1'b0;
    check("d_snz_ignored_music", 32'(music_out), 32'd1);
    check("d_snz_ignored_snz",   32'(snoozing),  32'd0);
`endif

    // Reset in the middle of a ring.
    reset = 1'b1; step(); reset = 1'b0;
    check("e_music",    32'(music_out),  32'd0);
    check("e_idx",      32'(ring_idx),   32'd0);
    check("e_snoozing", 32'(snoozing),   32'd0);
    check("e_armed",    32'(armed),      32'd0);
    check("e_pending",  32'(pending),    32'd0);
    check("e_wr_err",   32'(bus.wr_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
